lsu_mem: RTL and testbench

- Parametrised load/store unit with a byte-lane banked data memory. It is the next generation of the CPU's per-byte data_mem array.
- Adds selectable access size, sign/zero extension, misalignment detection, a configurable read latency and a valid/ready request/response handshake. This lets the core move to a multi-cycle datapath.
- Sits between the execute stage and data storage and holds one outstanding access at a time.

---
 rtl/lsu_mem.sv | 203 ++++++++++++++++++++
 tb/tb_lsu_mem.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem
//  Purpose  : Load/store unit over a byte-lane banked data memory. It accepts
//             one access at a time through a valid/ready request, and returns
//             the result through a valid/ready response after LAT cycles.
//             The access size is selectable, loads are sign- or zero-extended,
//             and misaligned or illegal-size accesses are flagged.
//  Ports    : clk, rstd (sync, active-low)
//             req_valid/req_ready, req_we, req_size, req_signed,
//             req_addr (byte address), req_wdata (right-justified)
//             rsp_valid/rsp_ready, rsp_rdata (extended load data), rsp_err
//  Revision : 1.0  initial release
// ============================================================================
module lsu_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int LAT    = 1,
  parameter int BA_W   = ADDR_W + $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [BA_W-1:0]   req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int c_LANES = DATA_W / 8;
  localparam int c_OFF_W = $clog2(c_LANES);
  localparam int c_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic   [1:0]          r_cnt;
  logic   [1:0]          w_cnt_nxt;

  logic                  w_accept;
  logic                  w_illegal;
  logic   [c_OFF_W-1:0]  w_off;
  logic   [ADDR_W-1:0]   w_waddr;
  logic   [c_LANES-1:0]  w_be_base;
  logic   [c_LANES-1:0]  w_be;
  logic   [DATA_W-1:0]   w_wshift;
  logic   [DATA_W-1:0]   w_rword;
  logic   [DATA_W-1:0]   w_shift;
  logic   [DATA_W-1:0]   w_mask;
  logic                  w_sign;
  logic   [DATA_W-1:0]   w_ext;

  // Attributes of the access in flight, captured on the accepting edge.
  logic                  r_we;
  logic   [1:0]          r_size;
  logic                  r_signed;
  logic   [c_OFF_W-1:0]  r_off;
  logic                  r_err;

  assign req_ready = rstd & (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_off     = req_addr[c_OFF_W-1:0];
  assign w_waddr   = req_addr[BA_W-1:c_OFF_W];

  // Alignment and size legality. A dword is only meaningful on a 64-bit bus.
  always_comb begin
    w_illegal = 1'b0;
    w_be_base = '0;
    case (req_size)
      2'd0: begin
        w_illegal = 1'b0;
        w_be_base = c_LANES'(1);
      end
      2'd1: begin
        w_illegal = req_addr[0];
        w_be_base = c_LANES'(3);
      end
      2'd2: begin
        w_illegal = |req_addr[1:0];
        w_be_base = c_LANES'(15);
      end
      default: begin
        w_illegal = (DATA_W != 64) | (|req_addr[2:0]);
        w_be_base = '1;
      end
    endcase
  end

  // Stores commit on the accepting edge, so a following load sees them.
  assign w_be     = (w_accept && req_we && !w_illegal) ? (w_be_base << w_off) : '0;
  assign w_wshift = req_wdata << {w_off, 3'b000};

  for (genvar l = 0; l < c_LANES; l++) begin : g_lane
    logic [7:0] r_bank [c_DEPTH];
    logic [7:0] r_rbyte;

    always_ff @(posedge clk) begin
      if (w_be[l]) begin
        r_bank[w_waddr] <= w_wshift[8*l +: 8];
      end
      if (w_accept && !req_we) begin
        r_rbyte <= r_bank[w_waddr];
      end
    end

    assign w_rword[8*l +: 8] = r_rbyte;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_off    <= w_off;
      r_err    <= w_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstd) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // BUSY is entered with LAT-1 and leaves when the count runs down to zero,
  // so RESP is reached on the LAT-th edge counting the accepting edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = 2'(LAT - 1);
          w_state_nxt = (LAT == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt <= 2'd1) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Bring the addressed lanes down to bit 0, then mask and extend by size.
  assign w_shift = w_rword >> {r_off, 3'b000};

  always_comb begin
    w_mask = '1;
    w_sign = 1'b0;
    case (r_size)
      2'd0: begin
        w_mask = DATA_W'(64'h0000_0000_0000_00FF);
        w_sign = w_shift[7];
      end
      2'd1: begin
        w_mask = DATA_W'(64'h0000_0000_0000_FFFF);
        w_sign = w_shift[15];
      end
      2'd2: begin
        w_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
        w_sign = w_shift[31];
      end
      default: begin
        w_mask = '1;
        w_sign = 1'b0;
      end
    endcase
  end

  assign w_ext     = (w_shift & w_mask) | ((r_signed & w_sign) ? ~w_mask : '0);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_ext : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem
//  Purpose  : Self-checking bench for lsu_mem. It instantiates a LAT=3 unit
//             for the main vector table, the hold test and the reset tests.
//             A LAT=1 unit exercises the direct IDLE->RESP path.
//             All expected values are hand-computed constants.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int BA_W   = 10;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  logic              clk = 1'b0;
  logic              rstd = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_valid1 = 1'b0;
  logic              rsp_ready = 1'b0;
  logic              rsp_ready1 = 1'b0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_signed = 1'b0;
  logic [BA_W-1:0]   req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready, req_ready1;
  logic              rsp_valid, rsp_valid1;
  logic              rsp_err, rsp_err1;
  logic [DATA_W-1:0] rsp_rdata, rsp_rdata1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(3)) u_dut (
    .clk(clk), .rstd(rstd),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  lsu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(1)) u_dut1 (
    .clk(clk), .rstd(rstd),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [9:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd; v.rd = rd; v.er = er;
    return v;
  endfunction

  // One full transaction on unit sel (0: LAT=3, 1: LAT=1). lat counts edges
  // from the accepting edge (inclusive) until rsp_valid is seen.
  task automatic run_vec(input int sel, input vec_t v, input int exp_lat, input string tag);
    int          lat;
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    req_we = v.we; req_size = v.sz; req_signed = v.sg;
    req_addr = v.addr; req_wdata = v.wd;
    if (sel == 1) req_valid1 = 1'b1; else req_valid = 1'b1;
    #1;
    chk($sformatf("%s ready", tag), 32'((sel == 1) ? req_ready1 : req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid1 = 1'b0;
    lat = 1;
    while ((((sel == 1) ? rsp_valid1 : rsp_valid) !== 1'b1) && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = (sel == 1) ? rsp_rdata1 : rsp_rdata;
    er = (sel == 1) ? rsp_err1 : rsp_err;
    chk($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s rdata", tag), rd, v.rd);
    chk($sformatf("%s err", tag), 32'(er), 32'(v.er));
    if (sel == 1) rsp_ready1 = 1'b1; else rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; rsp_ready1 = 1'b0;
  endtask

  vec_t vq[$];

  initial begin
    int   lat;
    logic seen;

    // Main table: {we, size, signed, addr, wdata, expected rdata, expected err}
    vq.push_back(mk(1, 2, 0, 'h010, 'hDEADBEEF, 'h00000000, 0));
    vq.push_back(mk(0, 0, 1, 'h013, 'h0,       'hFFFFFFDE, 0));
    vq.push_back(mk(0, 1, 0, 'h012, 'h0,       'h0000DEAD, 0));
    vq.push_back(mk(0, 0, 0, 'h010, 'h0,       'h000000EF, 0));
    vq.push_back(mk(0, 1, 1, 'h010, 'h0,       'hFFFFBEEF, 0));
    vq.push_back(mk(1, 0, 0, 'h011, 'h7F,      'h00000000, 0));
    vq.push_back(mk(0, 2, 0, 'h010, 'h0,       'hDEAD7FEF, 0));
    vq.push_back(mk(0, 0, 1, 'h011, 'h0,       'h0000007F, 0));
    vq.push_back(mk(0, 0, 1, 'h012, 'h0,       'hFFFFFFAD, 0));
    vq.push_back(mk(1, 2, 0, 'h020, 'h11223344, 'h00000000, 0));
    vq.push_back(mk(1, 1, 0, 'h021, 'hABCD,    'h00000000, 1));
    vq.push_back(mk(0, 2, 0, 'h022, 'h0,       'h00000000, 1));
    vq.push_back(mk(0, 2, 0, 'h020, 'h0,       'h11223344, 0));
    vq.push_back(mk(0, 3, 0, 'h020, 'h0,       'h00000000, 1));
    vq.push_back(mk(1, 3, 0, 'h020, 'hFFFFFFFF, 'h00000000, 1));
    vq.push_back(mk(0, 2, 0, 'h020, 'h0,       'h11223344, 0));
    vq.push_back(mk(1, 2, 0, 'h024, 'h00000000, 'h00000000, 0));
    vq.push_back(mk(1, 1, 0, 'h026, 'h8001,    'h00000000, 0));
    vq.push_back(mk(0, 1, 1, 'h026, 'h0,       'hFFFF8001, 0));
    vq.push_back(mk(0, 0, 1, 'h027, 'h0,       'hFFFFFF80, 0));
    vq.push_back(mk(1, 1, 0, 'h024, 'hAAAA5555, 'h00000000, 0));
    vq.push_back(mk(1, 0, 0, 'h025, 'h12345678, 'h00000000, 0));
    vq.push_back(mk(0, 2, 0, 'h024, 'h0,       'h80017855, 0));
    vq.push_back(mk(0, 1, 0, 'h026, 'h0,       'h00008001, 0));
    vq.push_back(mk(0, 2, 1, 'h024, 'h0,       'h80017855, 0));
    vq.push_back(mk(1, 2, 0, 'h3FC, 'h0F0F0F0F, 'h00000000, 0));
    vq.push_back(mk(0, 0, 1, 'h3FF, 'h0,       'h0000000F, 0));

    // Reset state
    rstd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst rsp_valid1", 32'(rsp_valid1), 32'd0);
    @(negedge clk);
    rstd = 1'b1;

    // Reset held with a store pending must not accept or write
    run_vec(0, mk(1, 2, 0, 'h030, 'hCAFEF00D, 'h0, 0), 3, "pre st30");
    @(negedge clk);
    rstd = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 'h030; req_wdata = 'h55555555;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rstv%0d req_ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("rstv%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rstd = 1'b1;
    @(posedge clk); #1;
    chk("release req_ready", 32'(req_ready), 32'd1);
    run_vec(0, mk(0, 2, 0, 'h030, 'h0, 'hCAFEF00D, 0), 3, "no-write ld30");

    // Table-driven vectors
    for (int i = 0; i < vq.size(); i++) begin
      run_vec(0, vq[i], 3, $sformatf("vec%0d", i));
    end

    // Response held off for 4 cycles: outputs stable, no new acceptance
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 'h010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold latency", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold%0d rdata", i), rsp_rdata, 32'hDEAD7FEF);
      chk($sformatf("hold%0d req_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hold done rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hold done req_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of a load: the response is dropped
    run_vec(0, mk(1, 2, 0, 'h040, 'h0BADF00D, 'h0, 0), 3, "midop st40");
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_addr = 'h040; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = rsp_valid;
    @(posedge clk);
    @(negedge clk);
    rstd = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    @(negedge clk);
    rstd = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid;
    end
    chk("midop no response", 32'(seen), 32'd0);
    run_vec(0, mk(0, 2, 0, 'h040, 'h0, 'h0BADF00D, 0), 3, "midop ld40");

    // LAT=1 unit: response on the edge after acceptance
    run_vec(1, mk(1, 2, 0, 'h008, 'hA5A51234, 'h0, 0), 1, "l1 st08");
    run_vec(1, mk(0, 1, 1, 'h00A, 'h0, 'hFFFFA5A5, 0), 1, "l1 ldh0A");
    run_vec(1, mk(0, 0, 0, 'h009, 'h0, 'h00000012, 0), 1, "l1 ldb09");
    run_vec(1, mk(0, 2, 0, 'h009, 'h0, 'h00000000, 1), 1, "l1 misal");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
